dma_channel_scheduler: RTL and testbench

Four-channel request scheduler that sits between the I/O devices, the MIPS CPU bus-grant logic and the single DMA engine. It holds one transfer descriptor per channel (DRAM start, IO start, word count, direction), arbitrates the devices' DREQ lines round-robin, and acquires the bus via HRQ/HLDA. It loads the winning descriptor into the DMA with an `update` pulse, returns DACK to the winner, and releases the bus on EOP.

---
 rtl/dma_channel_scheduler_if.sv | 38 +++
 rtl/dma_channel_scheduler.sv | 121 ++++++++++++
 tb/tb_dma_channel_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_channel_scheduler_if.sv
// dma_channel_scheduler_if: config, device handshake and DMA load bus of the channel scheduler
interface dma_channel_scheduler_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
);
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [ADDR_W-1:0] cfg_dram_addr;
    logic [ADDR_W-1:0] cfg_io_addr;
    logic [CNT_W-1:0]  cfg_count;
    logic              cfg_dir;
    logic [3:0]        DREQ;
    logic              HLDA;
    logic              EOP;
    logic              HRQ;
    logic [3:0]        DACK;
    logic              update;
    logic [ADDR_W-1:0] DRAM_startingAddress;
    logic [ADDR_W-1:0] IO_startingAddress;
    logic [CNT_W-1:0]  addressCounter;
    logic              IOR;
    logic              IOW;
    logic              busy;
    logic [3:0]        done;
    logic              cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_dram_addr, cfg_io_addr, cfg_count, cfg_dir, DREQ, HLDA, EOP,
        input  HRQ, DACK, update, DRAM_startingAddress, IO_startingAddress, addressCounter,
               IOR, IOW, busy, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_dram_addr, cfg_io_addr, cfg_count, cfg_dir, DREQ, HLDA, EOP,
        output HRQ, DACK, update, DRAM_startingAddress, IO_startingAddress, addressCounter,
               IOR, IOW, busy, done, cfg_err
    );
endinterface

// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: four-channel round-robin DREQ arbiter that acquires the bus and loads the DMA
module dma_channel_scheduler #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input logic CLK,
    input logic RST,
    dma_channel_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, LOAD, XFER, REL} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] dram_q [NUM_CH];
    logic [ADDR_W-1:0] io_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] dir_q, armed, eligible, done_p;
    logic [1:0]        ptr, act, win;
    logic              found, fin, abort, rej, err_p;

    assign eligible = bus.DREQ & armed;

    always_comb begin
        win = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && eligible[ptr + 2'(k)]) begin
                win = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else state <= state_n;
    end

    // EOP wins over a simultaneous HLDA drop, so abort only fires without EOP
    always_comb begin
        state_n = state;
        fin = 1'b0;
        abort = 1'b0;
        case (state)
            IDLE: state_n = found ? REQ : IDLE;
            REQ:  state_n = bus.HLDA ? LOAD : REQ;
            LOAD: state_n = XFER;
            XFER: begin
                fin = bus.EOP;
                abort = !bus.EOP && !bus.HLDA;
                state_n = (fin || abort) ? REL : XFER;
            end
            REL:  state_n = bus.HLDA ? REL : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // a write racing the completing EOP re-arms the channel instead of being rejected
    assign rej = bus.cfg_we && state != IDLE && bus.cfg_ch == act && !fin;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr <= '0;
            act <= '0;
            armed <= '0;
            dir_q <= '0;
            done_p <= '0;
            err_p <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                dram_q[i] <= '0;
                io_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            done_p <= fin ? NUM_CH'(1) << act : '0;
            err_p <= rej || abort;
            if (state == IDLE && found) begin
                act <= win;
                ptr <= win + 2'd1;
            end
            if (fin) armed[act] <= 1'b0;
            if (bus.cfg_we && !rej) begin
                armed[bus.cfg_ch] <= bus.cfg_count != '0;
                dram_q[bus.cfg_ch] <= bus.cfg_dram_addr;
                io_q[bus.cfg_ch] <= bus.cfg_io_addr;
                cnt_q[bus.cfg_ch] <= bus.cfg_count;
                dir_q[bus.cfg_ch] <= bus.cfg_dir;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.HRQ <= 1'b0;
            bus.DACK <= '0;
            bus.update <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= '0;
            bus.cfg_err <= 1'b0;
            bus.IOR <= 1'b0;
            bus.IOW <= 1'b0;
            bus.DRAM_startingAddress <= '0;
            bus.IO_startingAddress <= '0;
            bus.addressCounter <= '0;
        end else begin
            bus.HRQ <= state == REQ || state == LOAD || state == XFER;
            bus.DACK <= state == XFER ? NUM_CH'(1) << act : '0;
            bus.update <= state == LOAD;
            bus.busy <= state != IDLE;
            bus.done <= done_p;
            bus.cfg_err <= err_p;
            bus.IOR <= state == LOAD ? dir_q[act] : state == XFER && bus.IOR;
            bus.IOW <= state == LOAD ? !dir_q[act] : state == XFER && bus.IOW;
            if (state == LOAD) begin
                bus.DRAM_startingAddress <= dram_q[act];
                bus.IO_startingAddress <= io_q[act];
                bus.addressCounter <= cnt_q[act];
            end
        end
    end
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// tb_dma_channel_scheduler: directed table, corner sequences and random transfers against a channel model
module tb_dma_channel_scheduler;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dma_channel_scheduler_if #(.ADDR_W(10), .CNT_W(10)) bus();
    dma_channel_scheduler #(.NUM_CH(4), .ADDR_W(10), .CNT_W(10)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        int ch, dram, io, cnt, dir, dack, ior, iow;
    } vec_t;

    int passed = 0, total = 0;
    int m_dram [4], m_io [4], m_cnt [4], m_dir [4];
    bit m_armed [4];
    int m_ptr = 0;
    int cap_dack, cap_ior, cap_iow, cap_dram, cap_io, cap_cnt;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input int ch, input int dram, input int io, input int cnt, input int dir);
        bus.cfg_we = 1'b1;
        bus.cfg_ch = 2'(ch);
        bus.cfg_dram_addr = 10'(dram);
        bus.cfg_io_addr = 10'(io);
        bus.cfg_count = 10'(cnt);
        bus.cfg_dir = 1'(dir);
        tick;
        bus.cfg_we = 1'b0;
        m_dram[ch] = dram;
        m_io[ch] = io;
        m_cnt[ch] = cnt;
        m_dir[ch] = dir;
        m_armed[ch] = cnt != 0;
    endtask

    function automatic int pick(input int mask);
        for (int k = 0; k < 4; k++)
            if (mask[(m_ptr + k) % 4] && m_armed[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    // mode 0: EOP, 1: HLDA abort, 2: rejected write in XFER, 3: write racing EOP
    task automatic do_xfer(input int ch, input int mode, input int dly);
        int n, oh;
        oh = 1 << ch;
        n = 0;
        while (!bus.HRQ && n < 20) begin tick; n++; end
        check("hrq_rise", int'(bus.HRQ), 1);
        if (!bus.HRQ) return;
        check("dack_pre_grant", int'(bus.DACK), 0);
        m_ptr = (ch + 1) % 4;
        tick;
        bus.HLDA = 1'b1;
        n = 0;
        while (!bus.update && n < 10) begin tick; n++; end
        check("update", int'(bus.update), 1);
        check("upd_dack", int'(bus.DACK), 0);
        check("upd_dram", int'(bus.DRAM_startingAddress), m_dram[ch]);
        check("upd_io", int'(bus.IO_startingAddress), m_io[ch]);
        check("upd_cnt", int'(bus.addressCounter), m_cnt[ch]);
        check("upd_ior", int'(bus.IOR), m_dir[ch]);
        check("upd_iow", int'(bus.IOW), 1 - m_dir[ch]);
        cap_dram = int'(bus.DRAM_startingAddress);
        cap_io = int'(bus.IO_startingAddress);
        cap_cnt = int'(bus.addressCounter);
        cap_ior = int'(bus.IOR);
        cap_iow = int'(bus.IOW);
        tick;
        check("update_1cyc", int'(bus.update), 0);
        check("dack", int'(bus.DACK), oh);
        cap_dack = int'(bus.DACK);
        if (mode == 2) begin
            bus.cfg_we = 1'b1;
            bus.cfg_ch = 2'(ch);
            bus.cfg_dram_addr = 10'd123;
            bus.cfg_io_addr = 10'd456;
            bus.cfg_count = 10'd7;
            bus.cfg_dir = 1'(1 - m_dir[ch]);
            tick;
            bus.cfg_we = 1'b0;
            tick;
            check("rej_err", int'(bus.cfg_err), 1);
        end
        for (int i = 0; i < dly; i++) begin
            tick;
            check("dack_hold", int'(bus.DACK), oh);
        end
        if (mode == 1) bus.HLDA = 1'b0;
        else bus.EOP = 1'b1;
        if (mode == 3) begin
            bus.cfg_we = 1'b1;
            bus.cfg_ch = 2'(ch);
            bus.cfg_dram_addr = 10'd321;
            bus.cfg_io_addr = 10'd654;
            bus.cfg_count = 10'd9;
            bus.cfg_dir = 1'(1 - m_dir[ch]);
        end
        tick;
        bus.EOP = 1'b0;
        bus.cfg_we = 1'b0;
        check("dack_at_end", int'(bus.DACK), oh);
        tick;
        check("dack_drop", int'(bus.DACK), 0);
        check("hrq_drop", int'(bus.HRQ), 0);
        check("ior_drop", int'(bus.IOR | bus.IOW), 0);
        check("done", int'(bus.done), mode == 1 ? 0 : oh);
        check("end_err", int'(bus.cfg_err), mode == 1 ? 1 : 0);
        if (mode == 3) begin
            m_dram[ch] = 321;
            m_io[ch] = 654;
            m_cnt[ch] = 9;
            m_dir[ch] = 1 - m_dir[ch];
        end else if (mode != 1) m_armed[ch] = 1'b0;
        if (mode != 1) begin
            bus.HLDA = 1'b0;
            tick;
            check("done_1cyc", int'(bus.done), 0);
        end
    endtask

    vec_t vt [4];
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, w, mask, mode;
        vt[0] = '{0, 0, 10, 50, 1, 4'b0001, 1, 0};
        vt[1] = '{2, 70, 90, 40, 0, 4'b0100, 0, 1};
        vt[2] = '{1, 1023, 1, 1023, 1, 4'b0010, 1, 0};
        vt[3] = '{3, 5, 1000, 1, 0, 4'b1000, 0, 1};
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_dram_addr = '0; bus.cfg_io_addr = '0;
        bus.cfg_count = '0; bus.cfg_dir = 1'b0; bus.DREQ = '0; bus.HLDA = 1'b0; bus.EOP = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_dram[i] = 0; m_io[i] = 0; m_cnt[i] = 0; m_dir[i] = 0; m_armed[i] = 1'b0;
        end
        tick;
        tick;
        check("rst_hrq", int'(bus.HRQ), 0);
        check("rst_dack", int'(bus.DACK), 0);
        check("rst_misc", int'({bus.update, bus.IOR, bus.IOW, bus.busy, bus.cfg_err}), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_addr", int'(bus.DRAM_startingAddress | bus.IO_startingAddress | bus.addressCounter), 0);
        RST = 1'b0;

        for (int r = 0; r < 4; r++) begin
            cfg(vt[r].ch, vt[r].dram, vt[r].io, vt[r].cnt, vt[r].dir);
            bus.DREQ = 4'(1 << vt[r].ch);
            do_xfer(vt[r].ch, 0, 3);
            bus.DREQ = '0;
            check("vec_dack", cap_dack, vt[r].dack);
            check("vec_dram", cap_dram, vt[r].dram);
            check("vec_io", cap_io, vt[r].io);
            check("vec_cnt", cap_cnt, vt[r].cnt);
            check("vec_ior", cap_ior, vt[r].ior);
            check("vec_iow", cap_iow, vt[r].iow);
        end

        // round robin with all four requesting; each finished channel is re-armed
        for (int c = 0; c < 4; c++) cfg(c, 10 * c, 100 + c, 5 + c, c % 2);
        bus.DREQ = 4'hf;
        for (int i = 0; i < 5; i++) begin
            w = pick(15);
            do_xfer(w, 0, 5);
            check("rr_order", cap_dack, 1 << order[i]);
            if (i < 4) cfg(w, 20 + w, 40 + w, 60 + w, 1);
            else bus.DREQ = '0;
        end
        for (int c = 0; c < 4; c++) cfg(c, 0, 0, 0, 0);

        // grant is committed once HRQ is pending even if DREQ drops
        cfg(2, 70, 90, 40, 0);
        bus.DREQ = 4'b0100;
        tick;
        bus.DREQ = '0;
        do_xfer(2, 0, 2);
        check("dir0_ior", cap_ior, 0);
        check("dir0_iow", cap_iow, 1);

        cfg(1, 5, 5, 50, 1);
        cfg(1, 0, 0, 0, 0);
        bus.DREQ = 4'b0010;
        repeat (8) tick;
        check("disarm_hrq", int'(bus.HRQ), 0);
        check("disarm_busy", int'(bus.busy), 0);
        bus.DREQ = '0;

        cfg(3, 100, 200, 300, 1);
        bus.DREQ = 4'b1000;
        do_xfer(3, 2, 2);
        repeat (6) tick;
        check("rej_not_taken", int'(bus.HRQ), 0);
        bus.DREQ = '0;

        cfg(0, 11, 22, 33, 1);
        bus.DREQ = 4'b0001;
        do_xfer(0, 3, 1);
        do_xfer(0, 0, 1);
        bus.DREQ = '0;

        cfg(1, 300, 301, 302, 0);
        bus.DREQ = 4'b0010;
        do_xfer(1, 1, 2);
        do_xfer(1, 0, 1);
        bus.DREQ = '0;

        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 1) == 1)
                    cfg(c, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                        $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 1023)),
                        int'($urandom_range(0, 1)));
            mask = int'($urandom_range(0, 15));
            bus.DREQ = 4'(mask);
            w = pick(mask);
            if (w < 0) begin
                repeat (4) tick;
                check("rnd_idle", int'(bus.HRQ), 0);
            end else begin
                mode = $urandom_range(0, 3) == 0 ? 1 : 0;
                do_xfer(w, mode, int'($urandom_range(0, 3)));
            end
            bus.DREQ = '0;
        end

        // asynchronous reset in the middle of a transfer
        cfg(0, 1, 2, 3, 1);
        cfg(2, 4, 5, 6, 0);
        bus.DREQ = 4'b0001;
        n = 0;
        while (!bus.HRQ && n < 20) begin tick; n++; end
        check("arst_hrq", int'(bus.HRQ), 1);
        tick;
        bus.HLDA = 1'b1;
        n = 0;
        while (bus.DACK == 4'd0 && n < 20) begin tick; n++; end
        check("arst_pre_dack", int'(bus.DACK), 1);
        check("arst_pre_ior", int'(bus.IOR), 1);
        #3 RST = 1'b1;
        #1;
        check("arst_hrq_drop", int'(bus.HRQ), 0);
        check("arst_dack_drop", int'(bus.DACK), 0);
        check("arst_ior_drop", int'(bus.IOR), 0);
        bus.HLDA = 1'b0;
        tick;
        RST = 1'b0;
        bus.DREQ = 4'hf;
        repeat (5) tick;
        check("arst_idle", int'(bus.busy), 0);
        check("arst_disarmed", int'(bus.HRQ), 0);
        bus.DREQ = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
